// File: rtl/ef9345_bus_master.sv
// Host-side initiator for the EF9345 multiplexed AD bus: turns one valid/ready request
// into an address-latch plus data-strobe cycle, Motorola or Intel strobe convention.
module ef9345_bus_master #(
  parameter int INTEL_MODE = 0,
  parameter int T_ADDR     = 2,
  parameter int T_STROBE   = 3,
  parameter int T_HOLD     = 1
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in,
  output logic       as,
  output logic       ds,
  output logic       rw,
  output logic       cs_
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_ALAT = 3'd2,
    ST_DSET = 3'd3,
    ST_STRB = 3'd4,
    ST_HOLD = 3'd5
  } state_t;

  localparam logic [7:0] CNT_ADDR = 8'(T_ADDR - 1);
  localparam logic [7:0] CNT_STRB = 8'(T_STROBE - 1);
  localparam logic [7:0] CNT_HOLD = 8'(T_HOLD - 1);
  localparam logic       IDLE_LVL = (INTEL_MODE != 0) ? 1'b1 : 1'b0;

  state_t     state_r, state_nxt_s;
  logic [7:0] cnt_r, cnt_nxt_s;
  logic       rd_r, rd_nxt_s;
  logic [7:0] addr_r, addr_nxt_s, wdata_r, wdata_nxt_s;
  logic       accept_s, done_s, capture_s;
  logic       as_nxt_s, ds_nxt_s, rw_nxt_s, cs_nxt_s, oe_nxt_s;
  logic [7:0] bus_out_nxt_s;
  logic       addr_ph_s, data_ph_s, strb_ph_s;

  // Next-state logic, phase counter reload, and next values of every registered pin.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    done_s      = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_ADDR;
          cnt_nxt_s   = CNT_ADDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (cnt_r == 8'd0) begin
          state_nxt_s = ST_ALAT;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      ST_ALAT: state_nxt_s = ST_DSET;
      ST_DSET: begin
        state_nxt_s = ST_STRB;
        cnt_nxt_s   = CNT_STRB;
      end
      ST_STRB: begin
        if (cnt_r == 8'd0) begin
          state_nxt_s = ST_HOLD;
          cnt_nxt_s   = CNT_HOLD;
          capture_s   = rd_r;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_r == 8'd0) begin
          state_nxt_s = ST_IDLE;
          done_s      = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase

    // Fields are taken from the request only on the accept edge; otherwise held.
    if (accept_s) begin
      rd_nxt_s    = req_rd;
      addr_nxt_s  = req_addr;
      wdata_nxt_s = req_wdata;
    end else begin
      rd_nxt_s    = rd_r;
      addr_nxt_s  = addr_r;
      wdata_nxt_s = wdata_r;
    end

    addr_ph_s = (state_nxt_s == ST_ADDR) || (state_nxt_s == ST_ALAT);
    data_ph_s = (state_nxt_s == ST_DSET) || (state_nxt_s == ST_STRB) || (state_nxt_s == ST_HOLD);
    strb_ph_s = (state_nxt_s == ST_STRB);
    as_nxt_s  = (state_nxt_s == ST_ADDR);
    cs_nxt_s  = (state_nxt_s == ST_IDLE);
    oe_nxt_s  = addr_ph_s || (data_ph_s && !rd_nxt_s);
    if (addr_ph_s) begin
      bus_out_nxt_s = addr_nxt_s;
    end else if (data_ph_s) begin
      bus_out_nxt_s = wdata_nxt_s;
    end else begin
      bus_out_nxt_s = 8'h00;
    end
    // Intel: /RD low only during a read strobe, /WR low only during a write strobe.
    if (INTEL_MODE != 0) begin
      ds_nxt_s = !(strb_ph_s && rd_nxt_s);
      rw_nxt_s = !(strb_ph_s && !rd_nxt_s);
    end else begin
      ds_nxt_s = strb_ph_s;
      rw_nxt_s = data_ph_s && rd_nxt_s;
    end
  end

  // FSM state, phase counter and captured request fields.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      rd_r    <= 1'b0;
      addr_r  <= 8'h00;
      wdata_r <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      rd_r    <= rd_nxt_s;
      addr_r  <= addr_nxt_s;
      wdata_r <= wdata_nxt_s;
    end
  end

  // Registered bus pins and handshake outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      as        <= 1'b0;
      cs_       <= 1'b1;
      bus_oe    <= 1'b0;
      bus_out   <= 8'h00;
      ds        <= IDLE_LVL;
      rw        <= IDLE_LVL;
      rsp_valid <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      as        <= as_nxt_s;
      cs_       <= cs_nxt_s;
      bus_oe    <= oe_nxt_s;
      bus_out   <= bus_out_nxt_s;
      ds        <= ds_nxt_s;
      rw        <= rw_nxt_s;
      rsp_valid <= done_s;
      req_ready <= (state_nxt_s == ST_IDLE);
    end
  end

  // Read data sampled on the last strobe edge, while the slave is still driving.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= 8'h00;
    end else if (capture_s) begin
      rsp_rdata <= bus_in;
    end else begin
      rsp_rdata <= rsp_rdata;
    end
  end

endmodule

// File: tb/tb_ef9345_bus_master.sv
// Bench for ef9345_bus_master: three configurations (Motorola, Intel, minimum timing),
// each with a pin-level slave and a transaction-timing reference model.
module tb_ef9345_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  logic [2:0]      rst_n = 3'b000;
  logic [2:0]      req_valid = 3'b000;
  logic [2:0]      req_rd = 3'b000;
  logic [2:0][7:0] req_addr = '0;
  logic [2:0][7:0] req_wdata = '0;
  wire  [2:0]      req_ready, rsp_valid, bus_oe, as_v, ds_v, rw_v, cs_v;
  wire  [2:0][7:0] rsp_rdata, bus_out, bus_in;

  int terrs = 0;
  int tchecks = 0;

  task automatic tchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tchecks++;
    if (act !== exp) begin
      terrs++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int INTEL = (g == 1) ? 1 : 0;
    localparam int TA = (g == 2) ? 1 : 2;
    localparam int TS = (g == 2) ? 1 : 3;
    localparam int TH = 1;
    localparam int N  = TA + TS + TH + 2;

    ef9345_bus_master #(.INTEL_MODE(INTEL), .T_ADDR(TA), .T_STROBE(TS), .T_HOLD(TH)) u_dut (
      .clk_in(clk), .rst_n(rst_n[g]),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_rd(req_rd[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]),
      .bus_out(bus_out[g]), .bus_oe(bus_oe[g]), .bus_in(bus_in[g]),
      .as(as_v[g]), .ds(ds_v[g]), .rw(rw_v[g]), .cs_(cs_v[g])
    );

    // Slave: latches the register index on the as fall, commits a write at strobe end.
    logic [7:0] smem [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'hC3, 8'h16, 8'h17};
    logic [2:0] lat_r = 3'd0;
    logic [7:0] wcap_r = 8'h00;
    wire drive_s = !cs_v[g] && ((INTEL != 0) ? !ds_v[g] : rw_v[g]);
    assign bus_in[g] = drive_s ? smem[lat_r] : 8'hEE;

    always @(negedge as_v[g]) if (rst_n[g] && !cs_v[g]) lat_r <= bus_out[g][2:0];
    if (INTEL != 0) begin : g_intel
      always @(negedge rw_v[g]) if (!cs_v[g]) wcap_r <= bus_out[g];
      always @(posedge rw_v[g]) if (rst_n[g] && !cs_v[g]) smem[lat_r] <= wcap_r;
    end else begin : g_moto
      always @(posedge ds_v[g]) if (!rw_v[g] && !cs_v[g]) wcap_r <= bus_out[g];
      always @(negedge ds_v[g]) if (rst_n[g] && !rw_v[g] && !cs_v[g]) smem[lat_r] <= wcap_r;
    end

    // Reference model: a transaction accepted at edge acc occupies edges acc..acc+N-1.
    int cyc = 0, idle_at = 0, acc = 0;
    bit txn_v = 1'b0;
    logic m_rd = 1'b0;
    logic [7:0] m_addr = 8'h00, m_wdata = 8'h00, exp_rdata = 8'h00;
    logic [7:0] mmem [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'hC3, 8'h16, 8'h17};

    always @(posedge clk or negedge rst_n[g]) begin
      if (!rst_n[g]) begin
        idle_at   <= cyc;
        txn_v     <= 1'b0;
        exp_rdata <= 8'h00;
      end else begin
        if (txn_v && (cyc + 1 == acc + TA + 2 + TS)) begin
          if (m_rd) exp_rdata <= mmem[m_addr[2:0]];
          else mmem[m_addr[2:0]] <= m_wdata;
        end
        if (cyc >= idle_at && req_valid[g]) begin
          acc     <= cyc + 1;
          idle_at <= cyc + 1 + N;
          txn_v   <= 1'b1;
          m_rd    <= req_rd[g];
          m_addr  <= req_addr[g];
          m_wdata <= req_wdata[g];
        end
        cyc <= cyc + 1;
      end
    end

    int nerr = 0, nchk = 0;
    logic prev_as = 1'b0;

    task automatic c(input string nm, input logic [7:0] act, input logic [7:0] exp);
      nchk++;
      if (act !== exp) begin
        nerr++;
        $display("FAIL cfg%0d %s: got %h expected %h @%0t", g, nm, act, exp, $time);
      end
    endtask

    // Cycle-by-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
      bit busy, p_addr, p_alat, p_dset, p_strb, p_hold, e_oe, e_ds, e_rw;
      int o;
      busy   = txn_v && (cyc < idle_at);
      o      = cyc - acc;
      p_addr = busy && (o < TA);
      p_alat = busy && (o == TA);
      p_dset = busy && (o == TA + 1);
      p_strb = busy && (o >= TA + 2) && (o <= TA + 1 + TS);
      p_hold = busy && (o > TA + 1 + TS);
      e_oe   = p_addr || p_alat || (!m_rd && (p_dset || p_strb || p_hold));
      if (INTEL != 0) begin
        e_ds = !(p_strb && m_rd);
        e_rw = !(p_strb && !m_rd);
      end else begin
        e_ds = p_strb;
        e_rw = m_rd && (p_dset || p_strb || p_hold);
      end
      c("as", {7'd0, as_v[g]}, {7'd0, p_addr});
      c("cs_", {7'd0, cs_v[g]}, {7'd0, !busy});
      c("bus_oe", {7'd0, bus_oe[g]}, {7'd0, e_oe});
      c("ds", {7'd0, ds_v[g]}, {7'd0, e_ds});
      c("rw", {7'd0, rw_v[g]}, {7'd0, e_rw});
      c("req_ready", {7'd0, req_ready[g]}, {7'd0, !busy});
      c("rsp_valid", {7'd0, rsp_valid[g]}, {7'd0, rst_n[g] && txn_v && (cyc == idle_at)});
      c("rsp_rdata", rsp_rdata[g], exp_rdata);
      if (!rst_n[g]) c("bus_out_rst", bus_out[g], 8'h00);
      else if (e_oe) c("bus_out", bus_out[g], (p_addr || p_alat) ? m_addr : m_wdata);
      c("contention", {7'd0, drive_s && bus_oe[g]}, 8'h00);
      if (prev_as && !as_v[g] && rst_n[g]) begin
        c("cs_at_as_fall", {7'd0, cs_v[g]}, 8'h00);
        c("ds_at_as_fall", {7'd0, ds_v[g]}, (INTEL != 0) ? 8'h01 : 8'h00);
      end
      prev_as = as_v[g];
    end
  end

  task automatic issue(input int g, input logic rd, input logic [7:0] a, input logic [7:0] d,
                       output int acc);
    bit done = 1'b0;
    acc = -1;
    req_rd[g] = rd; req_addr[g] = a; req_wdata[g] = d; req_valid[g] = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      if (req_ready[g]) begin
        @(posedge clk); #1;
        acc = ecnt;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) tchk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input int g, input int acc, output int lat, output logic [7:0] rd,
                          output int n_as, output int n_ds1, output int n_ds0, output int n_rw0);
    bit got = 1'b0;
    lat = -1; rd = 8'h00; n_as = 0; n_ds1 = 0; n_ds0 = 0; n_rw0 = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (as_v[g]) n_as++;
      if (ds_v[g]) n_ds1++; else n_ds0++;
      if (!rw_v[g]) n_rw0++;
      if (rsp_valid[g]) begin
        got = 1'b1; lat = ecnt - acc; rd = rsp_rdata[g];
      end else begin
        req_addr[g] = 8'($urandom); req_wdata[g] = 8'($urandom); req_rd[g] = 1'($urandom);
      end
    end
    if (!got) tchk("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int a, a1, a2, a3, lat, nas, nd1, nd0, nr0;
    logic [7:0] rd;
    bit seen;
    repeat (3) @(negedge clk);
    tchk("rst_as", {31'd0, as_v[0]}, 32'd0);
    tchk("rst_cs_", {31'd0, cs_v[0]}, 32'd1);
    tchk("rst_intel_ds_rw", {30'd0, ds_v[1], rw_v[1]}, 32'd3);
    rst_n = 3'b111;
    @(negedge clk);

    // Motorola write 0x23 <- 0x5A
    issue(0, 1'b0, 8'h23, 8'h5A, a); req_valid[0] = 1'b0;
    wait_rsp(0, a, lat, rd, nas, nd1, nd0, nr0);
    tchk("t1_latency", lat, 32'd8);
    tchk("t1_as_cycles", nas, 32'd2);
    tchk("t1_ds_cycles", nd1, 32'd3);
    tchk("t1_rdata_untouched", {24'd0, rd}, 32'h00);
    tchk("t1_slave_r3", {24'd0, g_dut[0].smem[3]}, 32'h5A);

    // Motorola read 0x05
    issue(0, 1'b1, 8'h05, 8'h00, a); req_valid[0] = 1'b0;
    wait_rsp(0, a, lat, rd, nas, nd1, nd0, nr0);
    tchk("t2_latency", lat, 32'd8);
    tchk("t2_rdata", {24'd0, rd}, 32'hC3);

    // Intel write 0x01 <- 0x77, then read back
    issue(1, 1'b0, 8'h01, 8'h77, a); req_valid[1] = 1'b0;
    wait_rsp(1, a, lat, rd, nas, nd1, nd0, nr0);
    tchk("t3_wr_rw_low", nr0, 32'd3);
    tchk("t3_wr_ds_low", nd0, 32'd0);
    issue(1, 1'b1, 8'h01, 8'h00, a); req_valid[1] = 1'b0;
    wait_rsp(1, a, lat, rd, nas, nd1, nd0, nr0);
    tchk("t3_rd_ds_low", nd0, 32'd3);
    tchk("t3_rdata", {24'd0, rd}, 32'h77);

    // Back-to-back writes with req_valid held high
    issue(0, 1'b0, 8'h30, 8'hA1, a1);
    issue(0, 1'b0, 8'h31, 8'hA2, a2);
    issue(0, 1'b0, 8'h32, 8'hA3, a3);
    req_valid[0] = 1'b0;
    tchk("t4_spacing_1", a2 - a1, 32'd9);
    tchk("t4_spacing_2", a3 - a2, 32'd9);
    wait_rsp(0, a3, lat, rd, nas, nd1, nd0, nr0);
    tchk("t4_slave_r2", {24'd0, g_dut[0].smem[2]}, 32'hA3);

    // Reset in the middle of a Motorola write strobe
    @(negedge clk);
    issue(0, 1'b0, 8'h23, 8'h99, a); req_valid[0] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = ds_v[0];
    end
    tchk("t5_strobe_seen", {31'd0, seen}, 32'd1);
    #2 rst_n[0] = 1'b0;
    #1;
    tchk("t5_rst_pins", {27'd0, as_v[0], cs_v[0], bus_oe[0], ds_v[0], rw_v[0]}, 32'b01000);
    tchk("t5_rst_rsp", {31'd0, rsp_valid[0]}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (3) @(negedge clk);
    tchk("t5_slave_r3_kept", {24'd0, g_dut[0].smem[3]}, 32'h5A);
    issue(0, 1'b1, 8'h23, 8'h00, a); req_valid[0] = 1'b0;
    wait_rsp(0, a, lat, rd, nas, nd1, nd0, nr0);
    tchk("t5_after_rst_rdata", {24'd0, rd}, 32'h5A);

    // Minimum timing read
    issue(2, 1'b1, 8'h05, 8'h00, a); req_valid[2] = 1'b0;
    wait_rsp(2, a, lat, rd, nas, nd1, nd0, nr0);
    tchk("t6_latency", lat, 32'd5);
    tchk("t6_rdata", {24'd0, rd}, 32'hC3);

    // Randomized traffic on every configuration
    for (int g = 0; g < 3; g++) begin
      for (int t = 0; t < 20; t++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        issue(g, 1'($urandom), 8'($urandom), 8'($urandom), a);
        req_valid[g] = 1'b0;
        wait_rsp(g, a, lat, rd, nas, nd1, nd0, nr0);
      end
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tchk("mem_cfg0", {24'd0, g_dut[0].smem[i]}, {24'd0, g_dut[0].mmem[i]});
      tchk("mem_cfg1", {24'd0, g_dut[1].smem[i]}, {24'd0, g_dut[1].mmem[i]});
      tchk("mem_cfg2", {24'd0, g_dut[2].smem[i]}, {24'd0, g_dut[2].mmem[i]});
    end

    $display("Result: errors=%0d of %0d checks",
             terrs + g_dut[0].nerr + g_dut[1].nerr + g_dut[2].nerr,
             tchecks + g_dut[0].nchk + g_dut[1].nchk + g_dut[2].nchk);
    $finish;
  end

endmodule
